// File: rtl/rvga_types.sv
// Shared types for the RVGA memory stage.
//   rvga_cword  : control word travelling between pipeline stages
//   mem_state_e : memory-access FSM states
//   F3_*        : funct3 encodings for loads and stores
//   byte_en_t   : data-memory byte-enable vector
//   is_misaligned() : alignment check shared by the datapath and control
package rvga_types;

  localparam int RV_XLEN = 32;
  localparam int RV_BE_W = RV_XLEN / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_state_e;

  // Loads
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  // Stores
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef logic [RV_BE_W-1:0] byte_en_t;

  typedef struct packed {
    logic               valid;
    logic               is_load;
    logic               is_store;
    logic [2:0]         funct3;
    logic [RV_XLEN-1:0] alu_result;
    logic [RV_XLEN-1:0] rs2_data;
    logic [4:0]         rd;
    logic [RV_XLEN-1:0] rd_data;
  } rvga_cword;

  // funct3[1:0] encodes the access size for both loads and stores
  // (00 byte, 01 half, 10 word); the unsigned variants only differ in bit 2.
  function automatic logic is_misaligned(input logic [2:0] f3,
                                         input logic [1:0] addr_lo);
    case (f3[1:0])
      2'b01:   return addr_lo[0];
      2'b10:   return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory bus between the memory stage (master) and the memory (slave).
//   req_valid/req_ready : request handshake
//   we, addr, wdata, be : request fields, addr word-aligned
//   rsp_valid, rdata    : load response, no back-pressure
interface mem_access_if #(
  parameter int XLEN = 32,
  parameter int BE_W = XLEN / 8
);
  logic            req_valid;
  logic            req_ready;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [BE_W-1:0] be;
  logic            rsp_valid;
  logic [XLEN-1:0] rdata;

  modport master (
    output req_valid, we, addr, wdata, be,
    input  req_ready, rsp_valid, rdata
  );

  modport slave (
    input  req_valid, we, addr, wdata, be,
    output req_ready, rsp_valid, rdata
  );
endinterface

// File: rtl/mem_align.sv
// Combinational lane steering for the memory stage.
//   funct3, addr_lo : access size/sign and byte offset within the word
//   store_data      : rs2 value, replicated across lanes into wdata
//   be              : byte enables for stores (all ones for words)
//   load_raw        : word returned by memory
//   load_data       : selected lane, sign- or zero-extended
module mem_align
  import rvga_types::*;
#(
  parameter int XLEN = 32,
  parameter int BE_W = XLEN / 8
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] load_raw,
  output logic [XLEN-1:0] wdata,
  output logic [BE_W-1:0] be,
  output logic [XLEN-1:0] load_data
);

  function automatic logic [XLEN-1:0] ext_b(input logic signed [7:0] v,
                                            input logic sgn);
    return {{(XLEN-8){sgn & v[7]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] ext_h(input logic signed [15:0] v,
                                            input logic sgn);
    return {{(XLEN-16){sgn & v[15]}}, v};
  endfunction

  logic signed [7:0]  lane_b;
  logic signed [15:0] lane_h;

  always_comb begin
    lane_b    = load_raw[{addr_lo, 3'b000} +: 8];
    lane_h    = addr_lo[1] ? load_raw[31:16] : load_raw[15:0];
    load_data = load_raw;
    case (funct3)
      F3_LB:   load_data = ext_b(lane_b, 1'b1);
      F3_LH:   load_data = ext_h(lane_h, 1'b1);
      F3_LBU:  load_data = ext_b(lane_b, 1'b0);
      F3_LHU:  load_data = ext_h(lane_h, 1'b0);
      default: load_data = load_raw;
    endcase
  end

  always_comb begin
    wdata = store_data;
    be    = '1;
    case (funct3)
      F3_SB: begin
        wdata = {4{store_data[7:0]}};
        be    = 4'b0001 << addr_lo;
      end
      F3_SH: begin
        wdata = {2{store_data[15:0]}};
        be    = 4'b0011 << {addr_lo[1], 1'b0};
      end
      default: begin
        wdata = store_data;
        be    = '1;
      end
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory stage: forwards non-memory control words with one cycle latency and
// runs a single outstanding data-memory access for loads and stores.
//   clk, rst_n     : clock, synchronous active-low reset
//   stall_in       : downstream stall, holds mem_wb_cword
//   ex_mem_cword   : incoming control word from execute
//   mem_wb_cword   : registered control word to writeback
//   stall_out      : upstream stall while an access is in flight
//   dmem           : data-memory bus (master side)
//   misalign       : one-cycle pulse when a misaligned access is dropped
module mem_access
  import rvga_types::*;
#(
  parameter int XLEN = 32,
  parameter int BE_W = XLEN / 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall_in,
  input  rvga_cword     ex_mem_cword,
  output rvga_cword     mem_wb_cword,
  output logic          stall_out,
  mem_access_if.master  dmem,
  output logic          misalign
);

  mem_state_e      state, state_nxt;
  rvga_cword       held_p0;
  logic            ex_is_mem;
  logic            ex_mis;
  logic            accept;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] wdata;
  byte_en_t        be;

  assign ex_is_mem = ex_mem_cword.valid &
                     (ex_mem_cword.is_load | ex_mem_cword.is_store);
  assign ex_mis    = is_misaligned(ex_mem_cword.funct3,
                                   ex_mem_cword.alu_result[1:0]);
  assign accept    = (state == IDLE) & ex_is_mem & ~ex_mis & ~stall_in;

  // Steering always works from the latched word so bus fields stay stable.
  mem_align #(.XLEN(XLEN), .BE_W(BE_W)) u_align (
    .funct3     (held_p0.funct3),
    .addr_lo    (held_p0.alu_result[1:0]),
    .store_data (held_p0.rs2_data),
    .load_raw   (dmem.rdata),
    .wdata      (wdata),
    .be         (be),
    .load_data  (load_data)
  );

  assign dmem.req_valid = (state == REQ);
  assign dmem.we        = held_p0.is_store;
  assign dmem.addr      = {held_p0.alu_result[XLEN-1:2], 2'b00};
  assign dmem.wdata     = wdata;
  assign dmem.be        = be;

  // A misaligned access is dropped in IDLE, so it never stalls upstream.
  assign stall_out = (state != IDLE) | (ex_is_mem & ~ex_mis);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = REQ;
      REQ:  if (dmem.req_ready) state_nxt = held_p0.is_store ? DONE : WAIT;
      WAIT: if (dmem.rsp_valid) state_nxt = DONE;
      DONE: if (!stall_in) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage boundary: execute -> writeback register / access latch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      mem_wb_cword <= '0;
      held_p0      <= '0;
      misalign     <= 1'b0;
    end else begin
      state    <= state_nxt;
      misalign <= (state == IDLE) & ex_is_mem & ex_mis & ~stall_in;
      case (state)
        IDLE: begin
          if (ex_mem_cword.valid && !stall_in) begin
            if (!ex_is_mem)  mem_wb_cword <= ex_mem_cword;
            else if (ex_mis) mem_wb_cword <= '0;
            else             held_p0      <= ex_mem_cword;
          end
        end
        WAIT: if (dmem.rsp_valid) held_p0.rd_data <= load_data;
        DONE: if (!stall_in) mem_wb_cword <= held_p0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
  import rvga_types::*;

  logic      clk = 1'b0;
  logic      rst_n = 1'b0;
  logic      stall_in = 1'b0;
  rvga_cword ex_c;
  rvga_cword wb_c;
  logic      stall_out;
  logic      misalign;

  mem_access_if dmem_bus ();

  mem_access dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_in     (stall_in),
    .ex_mem_cword (ex_c),
    .mem_wb_cword (wb_c),
    .stall_out    (stall_out),
    .dmem         (dmem_bus),
    .misalign     (misalign)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] rd_data;
  } wb_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_exp_t;

  wb_exp_t   wb_q[$];
  req_exp_t  req_q[$];
  rvga_cword last_wb = '0;
  logic      mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic rvga_cword mk(input logic ld, input logic st,
                                   input logic [2:0] f3,
                                   input logic [31:0] addr,
                                   input logic [31:0] rs2,
                                   input logic [4:0] rd,
                                   input logic [31:0] rdd);
    rvga_cword c;
    c            = '0;
    c.valid      = 1'b1;
    c.is_load    = ld;
    c.is_store   = st;
    c.funct3     = f3;
    c.alu_result = addr;
    c.rs2_data   = rs2;
    c.rd         = rd;
    c.rd_data    = rdd;
    return c;
  endfunction

  // Writeback monitor: every change of mem_wb_cword is one emitted result.
  always @(negedge clk) begin
    wb_exp_t e;
    if (mon_en && (wb_c !== last_wb)) begin
      last_wb = wb_c;
      if (wb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL wb_unexpected: got valid=%0d rd_data=0x%08h expected no output",
                 wb_c.valid, wb_c.rd_data);
      end else begin
        e = wb_q.pop_front();
        chk("wb_valid", 32'(wb_c.valid), 32'(e.valid));
        if (e.valid) begin
          chk("wb_rd", 32'(wb_c.rd), 32'(e.rd));
          chk("wb_rd_data", wb_c.rd_data, e.rd_data);
        end
      end
    end
  end

  // Request monitor: compares bus fields at each handshake.
  always @(negedge clk) begin
    req_exp_t r;
    if (mon_en && dmem_bus.req_valid && dmem_bus.req_ready) begin
      if (req_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL req_unexpected: got addr=0x%08h expected no request",
                 dmem_bus.addr);
      end else begin
        r = req_q.pop_front();
        chk("req_addr", dmem_bus.addr, r.addr);
        chk("req_we", 32'(dmem_bus.we), 32'(r.we));
        if (r.we) begin
          chk("req_be", 32'(dmem_bus.be), 32'(r.be));
          chk("req_wdata", dmem_bus.wdata, r.wdata);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    ex_c               = '0;
    dmem_bus.req_ready = 1'b0;
    dmem_bus.rsp_valid = 1'b0;
    dmem_bus.rdata     = '0;

    // Reset state
    rst_n = 1'b0;
    repeat (2) cyc();
    chk("rst_wb_valid", 32'(wb_c.valid), 32'h0);
    chk("rst_wb_rd_data", wb_c.rd_data, 32'h0);
    chk("rst_req_valid", 32'(dmem_bus.req_valid), 32'h0);
    chk("rst_misalign", 32'(misalign), 32'h0);
    chk("rst_stall_out", 32'(stall_out), 32'h0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    cyc();

    // Stray response in IDLE must not change anything
    dmem_bus.rsp_valid = 1'b1;
    dmem_bus.rdata     = 32'hDEADBEEF;
    cyc();
    dmem_bus.rsp_valid = 1'b0;
    chk("idle_rsp_req_valid", 32'(dmem_bus.req_valid), 32'h0);

    // ALU op, latency 1
    ex_c = mk(1'b0, 1'b0, 3'b000, 32'h10, 32'h0, 5'd5, 32'h1234);
    #1;
    chk("alu_stall_out", 32'(stall_out), 32'h0);
    wb_q.push_back('{1'b1, 5'd5, 32'h1234});
    cyc();
    chk("alu_latency", wb_c.rd_data, 32'h1234);
    ex_c.valid = 1'b0;
    cyc();
    chk("invalid_hold", wb_c.rd_data, 32'h1234);

    // ALU op blocked by stall_in
    ex_c     = mk(1'b0, 1'b0, 3'b000, 32'h20, 32'h0, 5'd6, 32'h5678);
    stall_in = 1'b1;
    wb_q.push_back('{1'b1, 5'd6, 32'h5678});
    cyc();
    cyc();
    chk("stall_hold", wb_c.rd_data, 32'h1234);
    stall_in = 1'b0;
    cyc();
    ex_c.valid = 1'b0;
    chk("stall_release", wb_c.rd_data, 32'h5678);

    // LB 0x1003: ready after 2 cycles, concurrent rsp ignored, rsp later
    ex_c = mk(1'b1, 1'b0, F3_LB, 32'h1003, 32'h0, 5'd7, 32'h0);
    req_q.push_back('{32'h1000, 1'b0, 4'h0, 32'h0});
    wb_q.push_back('{1'b1, 5'd7, 32'hFFFFFF80});
    #1;
    chk("lb_stall_idle", 32'(stall_out), 32'h1);
    cyc();
    ex_c.valid = 1'b0;
    chk("lb_req_valid", 32'(dmem_bus.req_valid), 32'h1);
    chk("lb_stall_req", 32'(stall_out), 32'h1);
    cyc();
    chk("lb_req_held", 32'(dmem_bus.req_valid), 32'h1);
    chk("lb_addr_held", dmem_bus.addr, 32'h1000);
    dmem_bus.req_ready = 1'b1;
    dmem_bus.rsp_valid = 1'b1;
    dmem_bus.rdata     = 32'h000000AA;
    cyc();
    dmem_bus.req_ready = 1'b0;
    dmem_bus.rsp_valid = 1'b0;
    chk("lb_req_dropped", 32'(dmem_bus.req_valid), 32'h0);
    chk("lb_stall_wait", 32'(stall_out), 32'h1);
    cyc();
    dmem_bus.rsp_valid = 1'b1;
    dmem_bus.rdata     = 32'h80FFFFFF;
    cyc();
    dmem_bus.rsp_valid = 1'b0;
    chk("lb_stall_done", 32'(stall_out), 32'h1);
    cyc();
    chk("lb_result", wb_c.rd_data, 32'hFFFFFF80);
    chk("lb_stall_clear", 32'(stall_out), 32'h0);

    // SH 0x2002
    ex_c = mk(1'b0, 1'b1, F3_SH, 32'h2002, 32'h0000ABCD, 5'd0, 32'h77);
    req_q.push_back('{32'h2000, 1'b1, 4'b1100, 32'hABCDABCD});
    wb_q.push_back('{1'b1, 5'd0, 32'h77});
    cyc();
    ex_c.valid         = 1'b0;
    dmem_bus.req_ready = 1'b1;
    chk("sh_be", 32'(dmem_bus.be), 32'hC);
    cyc();
    dmem_bus.req_ready = 1'b0;
    chk("sh_not_yet", wb_c.rd_data, 32'hFFFFFF80);
    cyc();
    chk("sh_emitted", wb_c.rd_data, 32'h77);

    // LW 0x2001 misaligned
    ex_c = mk(1'b1, 1'b0, F3_LW, 32'h2001, 32'h0, 5'd8, 32'h0);
    wb_q.push_back('{1'b0, 5'd0, 32'h0});
    #1;
    chk("mis_stall_out", 32'(stall_out), 32'h0);
    cyc();
    ex_c.valid = 1'b0;
    chk("mis_pulse", 32'(misalign), 32'h1);
    chk("mis_no_req", 32'(dmem_bus.req_valid), 32'h0);
    chk("mis_bubble", 32'(wb_c.valid), 32'h0);
    cyc();
    chk("mis_pulse_end", 32'(misalign), 32'h0);
    chk("mis_no_req2", 32'(dmem_bus.req_valid), 32'h0);

    // LHU 0x3002 with response under stall_in
    ex_c = mk(1'b1, 1'b0, F3_LHU, 32'h3002, 32'h0, 5'd10, 32'h0);
    req_q.push_back('{32'h3000, 1'b0, 4'h0, 32'h0});
    wb_q.push_back('{1'b1, 5'd10, 32'h0000BEEF});
    cyc();
    ex_c.valid         = 1'b0;
    dmem_bus.req_ready = 1'b1;
    cyc();
    dmem_bus.req_ready = 1'b0;
    dmem_bus.rsp_valid = 1'b1;
    dmem_bus.rdata     = 32'hBEEF1234;
    stall_in           = 1'b1;
    cyc();
    dmem_bus.rsp_valid = 1'b0;
    chk("lhu_hold1", 32'(wb_c.valid), 32'h0);
    cyc();
    chk("lhu_hold2", 32'(wb_c.valid), 32'h0);
    cyc();
    chk("lhu_hold3", 32'(wb_c.valid), 32'h0);
    stall_in = 1'b0;
    cyc();
    chk("lhu_result", wb_c.rd_data, 32'h0000BEEF);

    // Reset while in WAIT, late response dropped
    ex_c = mk(1'b1, 1'b0, F3_LW, 32'h4000, 32'h0, 5'd9, 32'h0);
    req_q.push_back('{32'h4000, 1'b0, 4'h0, 32'h0});
    cyc();
    ex_c.valid         = 1'b0;
    dmem_bus.req_ready = 1'b1;
    cyc();
    dmem_bus.req_ready = 1'b0;
    wb_q.push_back('{1'b0, 5'd0, 32'h0});
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    chk("rstw_wb_zero", wb_c.rd_data, 32'h0);
    chk("rstw_stall_out", 32'(stall_out), 32'h0);
    dmem_bus.rsp_valid = 1'b1;
    dmem_bus.rdata     = 32'h12345678;
    cyc();
    dmem_bus.rsp_valid = 1'b0;
    cyc();
    chk("rstw_rsp_ignored", wb_c.rd_data, 32'h0);
    chk("rstw_req_valid", 32'(dmem_bus.req_valid), 32'h0);
    chk("rstw_idle", 32'(stall_out), 32'h0);

    repeat (2) cyc();
    chk("wb_queue_drained", 32'(wb_q.size()), 32'h0);
    chk("req_queue_drained", 32'(req_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
